// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx_arbiter slice: FSM state type and width helper.
// Build option: UART_ARB_FIXED_PRIO_EN selects lowest-index priority instead of round-robin.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_NB_DATA      = 8;
  localparam int unsigned DEF_HOLD_TIMEOUT = 1024;

  // Bits needed to index v distinct values (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational requester picker: first request at or after i_ptr (wrapping), or
// lowest-index request when UART_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDXW    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_idx,
  output logic               o_any
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_idx      = IDXW'(i);
        o_any      = 1'b1;
      end
    end
  end
`else
  int unsigned k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(i_ptr) + i) % NUM_REQ;
      if (!o_any && i_req[k[IDXW-1:0]]) begin
        o_grant[k[IDXW-1:0]] = 1'b1;
        o_idx                = k[IDXW-1:0];
        o_any                = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one uart_tx among NUM_REQ byte producers.
// Build option: UART_ARB_FIXED_PRIO_EN (fixed priority; no round-robin pointer).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned NB_DATA      = DEF_NB_DATA,
  parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [NUM_REQ*NB_DATA-1:0] i_data,
  input  logic [NUM_REQ-1:0]         i_last,
  output logic [NUM_REQ-1:0]         o_ready,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic                       o_tx_start,
  output logic [NB_DATA-1:0]         o_tx_data,
  input  logic                       i_tx_done
);

  localparam int unsigned IDXW = clog2(NUM_REQ);
  localparam int unsigned CNTW = clog2(HOLD_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDXW-1:0]    arb_idx;
  logic               arb_any;
  logic [IDXW-1:0]    arb_ptr;
  logic [IDXW-1:0]    owner_nxt;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDXW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_arbiter (
    .i_req   (i_valid),
    .i_ptr   (arb_ptr),
    .o_grant (arb_grant),
    .o_idx   (arb_idx),
    .o_any   (arb_any)
  );

  assign owner_nxt = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    o_ready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          o_ready = arb_grant;
          owner_d = arb_idx;
          grant_d = arb_grant;
          data_d  = i_data[arb_idx*NB_DATA +: NB_DATA];
          last_d  = i_last[arb_idx];
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (last_q) begin
            state_d = ST_IDLE;
            grant_d = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr_d   = owner_nxt;
`endif
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        // Owner keeps the transmitter between bytes; a byte arriving on the
        // timeout cycle still wins over the release.
        o_ready = grant_q;
        if (i_valid[owner_q]) begin
          data_d  = i_data[owner_q*NB_DATA +: NB_DATA];
          last_d  = i_last[owner_q];
          state_d = ST_START;
        end else if (cnt_q == CNTW'(HOLD_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_d   = owner_nxt;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_grant    = grant_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_tx_start = (state_q == ST_START);
  assign o_tx_data  = data_q;

  logic unused_owner_nxt;
  assign unused_owner_nxt = ^owner_nxt;

endmodule
